// File: rtl/cdu_incr_sched.sv
// Round-robin scheduler that moves banked CDU +/- increment requests onto the shared
// AGC counter-increment interface, granting at most one increment per AGC slot strobe.
module cdu_incr_sched #(
    parameter int NCH   = 5,
    parameter int ACC_W = 4,
    parameter int CH_W  = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            slot_stb,
    input  logic [NCH-1:0]  up_req,
    input  logic [NCH-1:0]  dn_req,
    input  logic            zero_all,
    output logic            out_valid,
    output logic [CH_W-1:0] out_ch,
    output logic            out_dir,
    input  logic            out_ready,
    output logic [NCH-1:0]  pend_nz,
    output logic [NCH-1:0]  ovf,
    output logic            slot_miss,
    input  logic            stat_clr
);

    // state  | meaning
    // IDLE   | waiting for a live or deferred slot strobe
    // SELECT | round-robin scan for a channel with a nonzero pending count
    // OFFER  | increment presented to the AGC driver until accepted
    typedef enum logic [1:0] {IDLE, SELECT, OFFER} state_t;

    localparam int EXT_W = ACC_W + 2;
    localparam logic signed [EXT_W-1:0] ONE  = EXT_W'(1);
    localparam logic signed [EXT_W-1:0] LIM  = EXT_W'(2 ** (ACC_W - 1) - 1);
    localparam logic signed [EXT_W-1:0] NLIM = -LIM;

    state_t                    state;
    logic signed [ACC_W-1:0]   acc      [NCH];
    logic signed [ACC_W-1:0]   acc_next [NCH];
    logic [CH_W-1:0]           rr_ptr;
    logic                      slot_pend;

    logic                      commit;
    logic [NCH-1:0]            sat;
    logic [NCH-1:0]            nz_next;
    logic signed [EXT_W-1:0]   delta;
    logic signed [EXT_W-1:0]   sum;
    logic                      found;
    logic [CH_W-1:0]           sel;
    logic                      sel_dir;
    int                        idx;
    logic                      miss_set;

    always_comb begin
        commit   = out_valid && out_ready && !zero_all;
        sat      = '0;
        nz_next  = '0;
        acc_next = '{default: '0};
        delta    = '0;
        sum      = '0;
        for (int i = 0; i < NCH; i++) begin
            delta = '0;
            if (up_req[i]) delta = delta + ONE;
            if (dn_req[i]) delta = delta - ONE;
            // The commit is taken back even if the count has since drained or flipped sign.
            if (commit && out_ch == CH_W'(i)) delta = out_dir ? delta + ONE : delta - ONE;
            sum = EXT_W'(acc[i]) + delta;
            if (sum > LIM) begin
                acc_next[i] = ACC_W'(LIM);
                sat[i]      = 1'b1;
            end else if (sum < NLIM) begin
                acc_next[i] = ACC_W'(NLIM);
                sat[i]      = 1'b1;
            end else begin
                acc_next[i] = ACC_W'(sum);
            end
            nz_next[i] = (acc_next[i] != '0);
        end
    end

    always_comb begin
        found   = 1'b0;
        sel     = '0;
        idx     = 0;
        for (int k = 1; k <= NCH; k++) begin
            idx = (int'(rr_ptr) + k) % NCH;
            if (!found && acc[idx] != '0) begin
                found = 1'b1;
                sel   = CH_W'(idx);
            end
        end
        sel_dir  = acc[sel][ACC_W-1];
        miss_set = slot_stb && (state != IDLE) && slot_pend;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '{default: '0};
            rr_ptr    <= CH_W'(NCH - 1);
            slot_pend <= 1'b0;
            out_valid <= 1'b0;
            out_ch    <= '0;
            out_dir   <= 1'b0;
            pend_nz   <= '0;
            ovf       <= '0;
            slot_miss <= 1'b0;
        end else if (zero_all) begin
            state     <= IDLE;
            acc       <= '{default: '0};
            slot_pend <= 1'b0;
            out_valid <= 1'b0;
            pend_nz   <= '0;
            if (stat_clr) begin
                ovf       <= '0;
                slot_miss <= 1'b0;
            end
        end else begin
            acc       <= acc_next;
            pend_nz   <= nz_next;
            ovf       <= stat_clr ? '0 : (ovf | sat);
            slot_miss <= stat_clr ? 1'b0 : (slot_miss | miss_set);
            if (slot_stb && state != IDLE && !slot_pend) slot_pend <= 1'b1;
            case (state)
                IDLE: begin
                    if (slot_stb || slot_pend) begin
                        state     <= SELECT;
                        slot_pend <= 1'b0;
                    end
                end
                SELECT: begin
                    if (found) begin
                        out_ch    <= sel;
                        out_dir   <= sel_dir;
                        rr_ptr    <= sel;
                        out_valid <= 1'b1;
                        state     <= OFFER;
                    end else begin
                        state <= IDLE;
                    end
                end
                OFFER: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cdu_incr_sched.sv
// Directed bench for cdu_incr_sched: expected grants are queued as stimulus is applied and
// popped as handshakes occur; status outputs are checked against hand-derived values.
module tb_cdu_incr_sched;

    localparam int NCH  = 5;
    localparam int CH_W = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic            slot_stb;
    logic [NCH-1:0]  up_req;
    logic [NCH-1:0]  dn_req;
    logic            zero_all;
    logic            out_valid;
    logic [CH_W-1:0] out_ch;
    logic            out_dir;
    logic            out_ready;
    logic [NCH-1:0]  pend_nz;
    logic [NCH-1:0]  ovf;
    logic            slot_miss;
    logic            stat_clr;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    logic [3:0] exp_q [$];
    logic [3:0] exp_g;

    cdu_incr_sched #(.NCH(NCH), .ACC_W(4), .CH_W(CH_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .slot_stb  (slot_stb),
        .up_req    (up_req),
        .dn_req    (dn_req),
        .zero_all  (zero_all),
        .out_valid (out_valid),
        .out_ch    (out_ch),
        .out_dir   (out_dir),
        .out_ready (out_ready),
        .pend_nz   (pend_nz),
        .ovf       (ovf),
        .slot_miss (slot_miss),
        .stat_clr  (stat_clr)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Scoreboard pop happens on the edge where a handshake is about to be taken.
    task automatic tick();
        if (out_valid && out_ready && !zero_all && !rst) begin
            check("grant_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                exp_g = exp_q.pop_front();
                check("grant_ch_dir", 32'({out_ch, out_dir}), 32'(exp_g));
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic pulse_up(input int ch, input int n);
        for (int j = 0; j < n; j++) begin
            up_req = NCH'(1 << ch);
            tick();
        end
        up_req = '0;
    endtask

    // One slot with ready high: SELECT next cycle, offer the cycle after, then handshake.
    task automatic grant_slot(input logic expect_valid);
        slot_stb = 1'b1;
        tick();
        slot_stb = 1'b0;
        check("lat_n1_valid", 32'(out_valid), 32'd0);
        tick();
        check("lat_n2_valid", 32'(out_valid), 32'(expect_valid));
        tick();
    endtask

    task automatic push_g(input int ch, input logic dir);
        exp_q.push_back({CH_W'(ch), dir});
    endtask

    initial begin
        rst = 1'b1; slot_stb = 1'b0; up_req = '0; dn_req = '0;
        zero_all = 1'b0; out_ready = 1'b0; stat_clr = 1'b0;
        tick(); tick();
        rst = 1'b0;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_ch", 32'(out_ch), 32'd0);
        check("rst_dir", 32'(out_dir), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        check("rst_miss", 32'(slot_miss), 32'd0);
        check("rst_pend", 32'(pend_nz), 32'd0);

        // Reset while offering
        pulse_up(3, 2);
        check("r_pend3", 32'(pend_nz), 32'h08);
        slot_stb = 1'b1; tick(); slot_stb = 1'b0; tick();
        check("r_offer_valid", 32'(out_valid), 32'd1);
        check("r_offer_ch", 32'(out_ch), 32'd3);
        out_ready = 1'b1; rst = 1'b1; tick(); rst = 1'b0;
        check("r_after_valid", 32'(out_valid), 32'd0);
        check("r_after_pend", 32'(pend_nz), 32'd0);
        check("r_after_ovf", 32'(ovf), 32'd0);
        up_req = 5'b10001; tick(); up_req = '0;
        push_g(0, 1'b0); push_g(4, 1'b0);
        grant_slot(1'b1);
        grant_slot(1'b1);
        check("r_drained", 32'(exp_q.size()), 32'd0);

        // Single channel
        pulse_up(2, 3);
        for (int j = 0; j < 3; j++) push_g(2, 1'b0);
        for (int j = 0; j < 3; j++) grant_slot(1'b1);
        grant_slot(1'b0);
        check("single_pend2", 32'(pend_nz[2]), 32'd0);
        check("single_drained", 32'(exp_q.size()), 32'd0);

        // Round-robin from a fresh pointer
        out_ready = 1'b0; rst = 1'b1; tick(); rst = 1'b0; out_ready = 1'b1;
        up_req = 5'b10001; dn_req = 5'b01000; tick();
        up_req = 5'b00001; dn_req = '0; tick(); up_req = '0;
        check("rr_pend", 32'(pend_nz), 32'h19);
        push_g(0, 1'b0); push_g(3, 1'b1); push_g(4, 1'b0); push_g(0, 1'b0);
        for (int j = 0; j < 4; j++) grant_slot(1'b1);
        check("rr_pend_zero", 32'(pend_nz), 32'd0);
        check("rr_drained", 32'(exp_q.size()), 32'd0);

        // Saturation on ch1
        pulse_up(1, 9);
        check("sat_ovf", 32'(ovf), 32'h02);
        up_req = 5'b00010; dn_req = 5'b00010; tick(); up_req = '0; dn_req = '0;
        check("sat_cancel_ovf", 32'(ovf), 32'h02);
        stat_clr = 1'b1; tick(); stat_clr = 1'b0;
        check("sat_clr", 32'(ovf), 32'd0);
        up_req = 5'b00010; stat_clr = 1'b1; tick(); up_req = '0; stat_clr = 1'b0;
        check("sat_clr_wins", 32'(ovf), 32'd0);
        for (int j = 0; j < 7; j++) push_g(1, 1'b0);
        for (int j = 0; j < 7; j++) grant_slot(1'b1);
        grant_slot(1'b0);
        check("sat_pend_zero", 32'(pend_nz), 32'd0);
        check("sat_drained", 32'(exp_q.size()), 32'd0);

        // Backpressure and slot deferral
        pulse_up(0, 3);
        out_ready = 1'b0;
        slot_stb = 1'b1; tick(); slot_stb = 1'b0; tick();
        check("bp_valid", 32'(out_valid), 32'd1);
        check("bp_ch_dir", 32'({out_ch, out_dir}), 32'h0);
        slot_stb = 1'b1; tick(); slot_stb = 1'b0;
        check("bp_miss_first", 32'(slot_miss), 32'd0);
        tick();
        slot_stb = 1'b1; tick(); slot_stb = 1'b0;
        check("bp_miss_set", 32'(slot_miss), 32'd1);
        check("bp_valid_held", 32'(out_valid), 32'd1);
        check("bp_ch_dir_held", 32'({out_ch, out_dir}), 32'h0);
        push_g(0, 1'b0); push_g(0, 1'b0);
        out_ready = 1'b1; tick();
        check("bp_idle_valid", 32'(out_valid), 32'd0);
        tick();
        check("bp_select_valid", 32'(out_valid), 32'd0);
        tick();
        check("bp_deferred_valid", 32'(out_valid), 32'd1);
        tick();
        check("bp_pend", 32'(pend_nz), 32'h01);
        check("bp_drained", 32'(exp_q.size()), 32'd0);
        stat_clr = 1'b1; tick(); stat_clr = 1'b0;
        check("bp_miss_clr", 32'(slot_miss), 32'd0);
        push_g(0, 1'b0);
        grant_slot(1'b1);
        check("bp_pend_zero", 32'(pend_nz), 32'd0);

        // zero_all during an offer with ready high
        pulse_up(3, 8);
        check("z_ovf_pre", 32'(ovf), 32'h08);
        slot_stb = 1'b1; tick(); slot_stb = 1'b0; tick();
        check("z_offer_valid", 32'(out_valid), 32'd1);
        zero_all = 1'b1; up_req = 5'b00100; tick(); zero_all = 1'b0; up_req = '0;
        check("z_valid", 32'(out_valid), 32'd0);
        check("z_pend", 32'(pend_nz), 32'd0);
        check("z_ovf_kept", 32'(ovf), 32'h08);
        grant_slot(1'b0);
        check("z_no_grants", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
